// File: rtl/pixel_write_master_if.sv
// Pixel-draw request handshake plus the Avalon-MM write port of the pixel write master.
interface pixel_write_master_if;
  logic        Draw;
  logic [31:0] Pixel_Address;
  logic [15:0] Color;
  logic        Write_Finish;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [15:0] avm_writedata;
  logic [1:0]  avm_byteenable;
  logic        avm_waitrequest;

  modport master (
    input  Draw, Pixel_Address, Color, avm_waitrequest,
    output Write_Finish, avm_address, avm_write, avm_writedata, avm_byteenable
  );

  modport slave (
    output Draw, Pixel_Address, Color, avm_waitrequest,
    input  Write_Finish, avm_address, avm_write, avm_writedata, avm_byteenable
  );
endinterface

// File: rtl/pixel_write_master.sv
// Clips one pixel request at a time against the frame-buffer window and writes it over Avalon-MM.
// Optional macro WRITE_TIMEOUT_EN adds a waitrequest timeout and the sticky timeout_err output.
module pixel_write_master #(
  parameter logic [31:0] FB_BASE        = 32'h08000000,
  parameter logic [31:0] FB_SPAN        = 32'h00040000,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 resetn,
  pixel_write_master_if.master bus,
  output logic [31:0]          pixel_count,
`ifdef WRITE_TIMEOUT_EN
  output logic                 timeout_err,
`endif
  output logic [15:0]          clip_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WRITE  = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  // The stall counter is 16 bits wide, so the limit must fit.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..65535");
  end

  logic [1:0]  state;
  logic [31:0] addr_p0;
  logic [15:0] data_p0;
  logic [31:0] req_addr;

  assign req_addr = {bus.Pixel_Address[31:1], 1'b0};

  // Offset is taken first so FB_BASE+FB_SPAN never has to be formed.
  function automatic logic in_window(input logic [31:0] a);
    logic [31:0] off;
    off = a - FB_BASE;
    return (a >= FB_BASE) && (off < FB_SPAN);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

`ifdef WRITE_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] stall_cnt;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      addr_p0     <= '0;
      data_p0     <= '0;
      pixel_count <= '0;
      clip_count  <= '0;
`ifdef WRITE_TIMEOUT_EN
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.Draw) begin
            addr_p0 <= req_addr;
            data_p0 <= bus.Color;
            if (in_window(req_addr)) begin
              state <= S_WRITE;
`ifdef WRITE_TIMEOUT_EN
              stall_cnt <= '0;
`endif
            end else begin
              clip_count <= sat_inc16(clip_count);
              state      <= S_FINISH;
            end
          end
        end
        S_WRITE: begin
          if (!bus.avm_waitrequest) begin
            pixel_count <= pixel_count + 32'd1;
            state       <= S_FINISH;
          end
`ifdef WRITE_TIMEOUT_EN
          else if (stall_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_FINISH;
          end else begin
            stall_cnt <= stall_cnt + 16'd1;
          end
`endif
        end
        // Draw is still the old request here, so it is deliberately not looked at.
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Bus strobes decode straight from state so an asynchronous reset drops them at once.
  assign bus.avm_write      = (state == S_WRITE);
  assign bus.avm_byteenable = {2{bus.avm_write}};
  assign bus.avm_address    = addr_p0;
  assign bus.avm_writedata  = data_p0;
  assign bus.Write_Finish   = (state == S_FINISH);

endmodule

// File: tb/tb_pixel_write_master.sv
// Randomized bench for pixel_write_master against a transaction-level window/counter model.
module tb_pixel_write_master;

  localparam logic [31:0] FB_BASE = 32'h08000000;
  localparam logic [31:0] FB_SPAN = 32'h00040000;
  localparam int          TO_CYC  = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] pixel_count;
  logic [15:0] clip_count;
`ifdef WRITE_TIMEOUT_EN
  logic        timeout_err;
`endif

  pixel_write_master_if bus();

  pixel_write_master #(
    .FB_BASE(FB_BASE), .FB_SPAN(FB_SPAN), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus),
    .pixel_count(pixel_count),
`ifdef WRITE_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .clip_count(clip_count)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  longint      exp_pix = 0;
  int          exp_clip = 0;
  logic [31:0] wr_log[$];
  logic [31:0] edge_addr [8];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bit model_in_window(input logic [31:0] a);
    longint pa;
    pa = longint'(a & 32'hFFFF_FFFE);
    return (pa >= longint'(FB_BASE)) && (pa < longint'(FB_BASE) + longint'(FB_SPAN));
  endfunction

  // Presents one request in the current (idle) cycle, plays the slave, returns in the cycle after FINISH.
  task automatic do_req(input logic [31:0] a, input logic [15:0] c, input int nwait, input bit drop_draw);
    bit          inw;
    logic [31:0] ea;
    int          first_wr, fin, stalls, xfers, wr_cycles, hold_bad;
    inw = model_in_window(a);
    ea  = a & 32'hFFFF_FFFE;
    first_wr = -1; fin = -1; stalls = 0; xfers = 0; wr_cycles = 0; hold_bad = 0;
    chk("idle_before_req", {bus.avm_write, bus.Write_Finish}, 2'b00);
    bus.Draw = 1'b1; bus.Pixel_Address = a; bus.Color = c;
    bus.avm_waitrequest = 1'($urandom_range(0, 1));
    for (int cyc = 1; cyc <= 64 && fin < 0; cyc++) begin
      @(posedge clk); @(negedge clk);
      if (drop_draw && cyc == 1) bus.Draw = 1'b0;
      if (bus.avm_write) begin
        wr_cycles++;
        if (first_wr < 0) first_wr = cyc;
        if (bus.avm_address !== ea || bus.avm_writedata !== c || bus.avm_byteenable !== 2'b11)
          hold_bad++;
        if (stalls < nwait) begin
          bus.avm_waitrequest = 1'b1; stalls++;
        end else begin
          bus.avm_waitrequest = 1'b0; xfers++; wr_log.push_back(bus.avm_address);
        end
      end else begin
        if (bus.avm_byteenable !== 2'b00) hold_bad++;
        bus.avm_waitrequest = 1'($urandom_range(0, 1));
      end
      if (bus.Write_Finish) fin = cyc;
    end
    if (inw) exp_pix++;
    else if (exp_clip < 65535) exp_clip++;
    chk("finish_seen", fin >= 0, 1'b1);
    chk("finish_latency", fin, inw ? nwait + 2 : 1);
    chk("first_write_cycle", first_wr, inw ? 1 : -1);
    chk("write_cycles", wr_cycles, inw ? nwait + 1 : 0);
    chk("transfers", xfers, inw ? 1 : 0);
    chk("bus_hold", hold_bad, 0);
    chk("pixel_count", pixel_count, exp_pix[31:0]);
    chk("clip_count", clip_count, exp_clip[15:0]);
    // The old request stays visible through FINISH and must not be taken again.
    @(posedge clk); @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    bus.Draw = 1'b0;
    bus.Pixel_Address = $urandom;
    repeat (n) begin @(posedge clk); @(negedge clk); end
  endtask

  function automatic logic [31:0] rand_addr();
    int pick;
    pick = $urandom_range(0, 9);
    if (pick <= 5) return FB_BASE + 32'($urandom_range(0, FB_SPAN - 1));
    if (pick == 6) return edge_addr[$urandom_range(0, 7)];
    if (pick == 7) return $urandom;
    if (pick == 8) return FB_BASE - 32'($urandom_range(1, 64));
    return FB_BASE + FB_SPAN + 32'($urandom_range(0, 64));
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    edge_addr[0] = FB_BASE;
    edge_addr[1] = FB_BASE + 32'd1;
    edge_addr[2] = FB_BASE + FB_SPAN - 32'd2;
    edge_addr[3] = FB_BASE + FB_SPAN - 32'd1;
    edge_addr[4] = FB_BASE + FB_SPAN;
    edge_addr[5] = FB_BASE - 32'd1;
    edge_addr[6] = FB_BASE - 32'd2;
    edge_addr[7] = 32'hFFFF_FFFF;

    resetn = 1'b0;
    bus.Draw = 1'b0; bus.Pixel_Address = '0; bus.Color = '0; bus.avm_waitrequest = 1'b0;
    #12;
    chk("rst_write", bus.avm_write, 1'b0);
    chk("rst_finish", bus.Write_Finish, 1'b0);
    chk("rst_address", bus.avm_address, 32'h0);
    chk("rst_writedata", bus.avm_writedata, 16'h0);
    chk("rst_byteenable", bus.avm_byteenable, 2'b00);
    chk("rst_pixel_count", pixel_count, 32'h0);
    chk("rst_clip_count", clip_count, 16'h0);
`ifdef WRITE_TIMEOUT_EN
    chk("rst_timeout_err", timeout_err, 1'b0);
`endif
    @(negedge clk); resetn = 1'b1;
    @(negedge clk);

    do_req(32'h08000400, 16'hF800, 0, 1'b0);
    idle_cycles(1);
    do_req(32'h08000404, 16'h07E0, 5, 1'b0);
    idle_cycles(2);
    do_req(32'h08040000, 16'h001F, 0, 1'b0);
    do_req(32'h07FFFFFE, 16'h001F, 0, 1'b0);
    idle_cycles(1);

    // Line circuit style: next pixel presented right after each Write_Finish.
    wr_log.delete();
    for (int x = 0; x < 4; x++)
      do_req(FB_BASE + 32'(2 * x), 16'(16'h1234 + x), $urandom_range(0, 2), 1'b0);
    idle_cycles(1);
    chk("line_writes", wr_log.size(), 4);
    for (int x = 0; x < 4 && x < wr_log.size(); x++)
      chk("line_addr", wr_log[x], FB_BASE + 32'(2 * x));

    for (int i = 0; i < 60; i++) begin
      do_req(rand_addr(), 16'($urandom), $urandom_range(0, 4), 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 3));
    end
    idle_cycles(1);

    // Asynchronous reset in the middle of a stalled write.
    bus.Draw = 1'b1; bus.Pixel_Address = FB_BASE + 32'h100; bus.Color = 16'hAAAA;
    bus.avm_waitrequest = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("pre_reset_write", bus.avm_write, 1'b1);
    @(posedge clk); #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_write", bus.avm_write, 1'b0);
    chk("async_rst_finish", bus.Write_Finish, 1'b0);
    chk("async_rst_pixel_count", pixel_count, 32'h0);
    chk("async_rst_clip_count", clip_count, 16'h0);
    bus.Draw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold_finish", bus.Write_Finish, 1'b0);
    end
    resetn = 1'b1;
    exp_pix = 0; exp_clip = 0;
    @(negedge clk);
    do_req(FB_BASE + 32'h200, 16'h5555, 1, 1'b0);
    idle_cycles(1);

`ifdef WRITE_TIMEOUT_EN
    begin
      int wr_cycles, fin;
      wr_cycles = 0; fin = -1;
      chk("timeout_err_before", timeout_err, 1'b0);
      bus.Draw = 1'b1; bus.Pixel_Address = FB_BASE + 32'h300; bus.Color = 16'hBEEF;
      bus.avm_waitrequest = 1'b1;
      for (int cyc = 1; cyc <= 64 && fin < 0; cyc++) begin
        @(posedge clk); @(negedge clk);
        if (bus.avm_write) wr_cycles++;
        if (bus.Write_Finish) fin = cyc;
      end
      chk("timeout_write_cycles", wr_cycles, TO_CYC);
      chk("timeout_finish_latency", fin, TO_CYC + 1);
      chk("timeout_err_set", timeout_err, 1'b1);
      chk("timeout_pixel_count", pixel_count, exp_pix[31:0]);
      bus.avm_waitrequest = 1'b0;
      @(posedge clk); @(negedge clk);
      idle_cycles(1);
      do_req(FB_BASE + 32'h304, 16'h0F0F, 0, 1'b0);
      chk("timeout_err_sticky", timeout_err, 1'b1);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
